// File: rtl/add_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor: WIDTH bits split into STAGES segments,
// each built from 4-bit CLA groups, with the inter-segment carry registered.
module add_cla_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iC,
    input  logic             iSub,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oS,
    output logic             oC,
    output logic             oV
);

    // WIDTH must be a multiple of 4*STAGES so every segment holds whole CLA groups.
    localparam int SEG = WIDTH / STAGES;
    localparam int NG  = SEG / 4;

    // Segment adder: returns {carry_out, sum}. Group G/P drive a lookahead across the
    // groups; inside a group the bit carries use the same generate/propagate terms.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           cin);
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG-1:0] s;
        logic [NG:0]    gc;
        logic           c;
        logic           gg;
        logic           gp;
        g     = a & b;
        p     = a | b;
        s     = '0;
        gc    = '0;
        gc[0] = cin;
        for (int j = 0; j < NG; j++) begin
            gg = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp = &p[4*j +: 4];
            gc[j+1] = gg | (gp & gc[j]);
            c = gc[j];
            for (int i = 0; i < 4; i++) begin
                s[4*j+i] = a[4*j+i] ^ b[4*j+i] ^ c;
                c        = g[4*j+i] | (p[4*j+i] & c);
            end
        end
        return {gc[NG], s};
    endfunction

    // d_q[k] holds finished sum segments 0..k in its low bits and the still-unconsumed
    // A bits above them; b_q[k] carries the (possibly inverted) B operand forward.
    logic [WIDTH-1:0]  d_q  [STAGES];
    logic [WIDTH-1:0]  b_q  [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;
    logic              ov_q;

    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  d_nx [STAGES];
    logic [SEG:0]      r    [STAGES];
    logic [STAGES-1:0] c_in;
    logic              ov_nx;
    logic              en;

    // Handshake: one global enable en = ~oValid | iReady, exported as oReady. An operation
    // is taken on iValid & oReady, a result leaves on oValid & iReady; when en is low every
    // stage holds, bubbles included.
    assign en     = ~v_q[STAGES-1] | iReady;
    assign oReady = en;

    always_comb begin
        a_in[0] = iA;
        b_in[0] = iSub ? ~iB : iB;
        c_in    = '0;
        c_in[0] = iC;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = d_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            r[k]    = seg_add(a_in[k][k*SEG +: SEG], b_in[k][k*SEG +: SEG], c_in[k]);
            d_nx[k] = a_in[k];
            d_nx[k][k*SEG +: SEG] = r[k][SEG-1:0];
        end
        // Carry into the MSB recovered as a ^ b ^ s at that bit.
        ov_nx = a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1]
              ^ d_nx[STAGES-1][WIDTH-1] ^ r[STAGES-1][SEG];
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
                b_q[k] <= '0;
            end
            c_q  <= '0;
            v_q  <= '0;
            ov_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= d_nx[k];
                b_q[k] <= b_in[k];
                c_q[k] <= r[k][SEG];
            end
            v_q[0] <= iValid;
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
            end
            ov_q <= ov_nx;
        end
    end

    assign oValid = v_q[STAGES-1];
    assign oS     = d_q[STAGES-1];
    assign oC     = c_q[STAGES-1];
    assign oV     = ov_q;

endmodule

// File: tb/tb_add_cla_pipe.sv
// Bench for add_cla_pipe: directed corner cases plus random traffic checked against an
// arithmetic reference and an in-order expected queue.
module tb_add_cla_pipe;

    localparam int W = 32;
    localparam int S = 4;

    logic         iClk   = 1'b0;
    logic         iRst   = 1'b1;
    logic         iValid = 1'b0;
    logic         iReady = 1'b1;
    logic         iC     = 1'b0;
    logic         iSub   = 1'b0;
    logic [W-1:0] iA     = '0;
    logic [W-1:0] iB     = '0;
    logic         oReady;
    logic         oValid;
    logic         oC;
    logic         oV;
    logic [W-1:0] oS;

    int tests_run    = 0;
    int tests_failed = 0;
    bit mon_en       = 1'b0;

    logic [W+1:0] exp_q[$];
    bit           vq[S];

    always #5 iClk = ~iClk;

    add_cla_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
        .iA(iA), .iB(iB), .iC(iC), .iSub(iSub),
        .oValid(oValid), .iReady(iReady), .oS(oS), .oC(oC), .oV(oV)
    );

    // Reference result packed as {V, C, S}.
    function automatic logic [W+1:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic c, input logic sub);
        logic [W-1:0] bb;
        logic [W:0]   sum;
        logic         ov;
        bb  = sub ? ~b : b;
        sum = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        ov  = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
        return {ov, sum[W], sum[W-1:0]};
    endfunction

    // Model: S slots that all advance whenever the output is empty or being taken.
    always @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < S; i++) vq[i] = 1'b0;
            exp_q.delete();
        end else if (!vq[S-1] || iReady) begin
            if (iValid) exp_q.push_back(model_add(iA, iB, iC, iSub));
            for (int i = S - 1; i > 0; i--) vq[i] = vq[i-1];
            vq[0] = iValid;
        end
    end

    // Scoreboard, sampled mid-cycle while inputs are stable.
    always @(negedge iClk) begin
        if (mon_en) begin
            tests_run++;
            if (oValid !== vq[S-1]) begin
                tests_failed++;
                $display("FAIL mon_valid: got %0b want %0b at %0t", oValid, vq[S-1], $time);
            end
            tests_run++;
            if (oReady !== (!vq[S-1] || iReady)) begin
                tests_failed++;
                $display("FAIL mon_ready: got %0b want %0b at %0t", oReady, (!vq[S-1] || iReady), $time);
            end
            if (vq[S-1] && exp_q.size() > 0) begin
                tests_run++;
                if ({oV, oC, oS} !== exp_q[0]) begin
                    tests_failed++;
                    $display("FAIL mon_result: got V=%0b C=%0b S=%h want V=%0b C=%0b S=%h at %0t",
                             oV, oC, oS, exp_q[0][W+1], exp_q[0][W], exp_q[0][W-1:0], $time);
                end
                if (iReady) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive_idle(input logic rdy);
        @(posedge iClk); #1;
        iValid = 1'b0;
        iA     = $urandom;
        iB     = $urandom;
        iC     = 1'($urandom_range(0, 1));
        iSub   = 1'($urandom_range(0, 1));
        iReady = rdy;
        #1;
    endtask

    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic sub, input logic rdy);
        @(posedge iClk); #1;
        iValid = 1'b1;
        iA     = a;
        iB     = b;
        iC     = c;
        iSub   = sub;
        iReady = rdy;
        #1;
    endtask

    task automatic drain();
        repeat (S + 1) drive_idle(1'b1);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge iClk);
        #1 iRst = 1'b0;
        #1;
        tests_run++;
        if ({oValid, oC, oV} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got valid/c/v=%b want 000", {oValid, oC, oV});
        end
        tests_run++;
        if (oS !== '0) begin
            tests_failed++;
            $display("FAIL reset_sum: got %h want 0", oS);
        end
        tests_run++;
        if (oReady !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %0b want 1", oReady);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[5] = '{32'hFFFF_FFFF, 32'd5, 32'd7, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [W-1:0] tb[5] = '{32'd1, 32'd7, 32'd5, 32'd1, 32'd1};
        logic         tc[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic         ts[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] es[5] = '{32'h0, 32'hFFFF_FFFE, 32'd2, 32'h8000_0000, 32'h7FFF_FFFF};
        logic         ec[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic         ev[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat;
        for (int n = 0; n < 5; n++) begin
            drain();
            drive_op(ta[n], tb[n], tc[n], ts[n], 1'b1);
            lat = -1;
            for (int i = 1; i <= 2 * S; i++) begin
                drive_idle(1'b1);
                if (oValid === 1'b1) begin
                    lat = i;
                    break;
                end
            end
            tests_run++;
            if (lat != S) begin
                tests_failed++;
                $display("FAIL dir%0d_latency: got %0d want %0d", n, lat, S);
            end
            tests_run++;
            if (oS !== es[n]) begin
                tests_failed++;
                $display("FAIL dir%0d_sum: got %h want %h", n, oS, es[n]);
            end
            tests_run++;
            if (oC !== ec[n]) begin
                tests_failed++;
                $display("FAIL dir%0d_carry: got %0b want %0b", n, oC, ec[n]);
            end
            tests_run++;
            if (oV !== ev[n]) begin
                tests_failed++;
                $display("FAIL dir%0d_ovf: got %0b want %0b", n, oV, ev[n]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int last  = -1;
        int cnt   = 0;
        drain();
        for (int j = 0; j < 16; j++) begin
            if (j < 10) drive_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            else        drive_idle(1'b1);
            if (oValid === 1'b1) begin
                if (first < 0) first = j;
                last = j;
                cnt++;
            end
        end
        tests_run++;
        if (first != S || last != S + 9 || cnt != 10) begin
            tests_failed++;
            $display("FAIL b2b_stream: got first=%0d last=%0d count=%0d want first=%0d last=%0d count=10",
                     first, last, cnt, S, S + 9);
        end
        drain();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_drain: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [W+1:0] first_exp = '0;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         sub;
        int first = -1;
        int last  = -1;
        int cnt   = 0;
        drain();
        for (int j = 0; j < 4; j++) begin
            a   = $urandom;
            b   = $urandom;
            c   = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            if (j == 0) first_exp = model_add(a, b, c, sub);
            drive_op(a, b, c, sub, 1'b1);
        end
        // Offer new operations while stalled; none may be taken.
        for (int k = 0; k < 6; k++) begin
            drive_op($urandom, $urandom, 1'b1, 1'b0, 1'b0);
            tests_run++;
            if (oReady !== 1'b0 || oValid !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_stall%0d: got ready=%0b valid=%0b want ready=0 valid=1", k, oReady, oValid);
            end
            tests_run++;
            if ({oV, oC, oS} !== first_exp) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got %h want %h", k, {oV, oC, oS}, first_exp);
            end
        end
        for (int m = 0; m < 7; m++) begin
            drive_idle(1'b1);
            if (oValid === 1'b1) begin
                if (first < 0) first = m;
                last = m;
                cnt++;
            end
        end
        tests_run++;
        if (first != 0 || last != 3 || cnt != 4) begin
            tests_failed++;
            $display("FAIL bp_drain: got first=%0d last=%0d count=%0d want 0 3 4", first, last, cnt);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_pending: got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        drain();
        for (int j = 0; j < 3; j++) drive_op($urandom | 32'h1, $urandom, 1'b1, 1'b0, 1'b1);
        @(posedge iClk); #1;
        iRst   = 1'b1;
        iValid = 1'b0;
        iReady = 1'b1;
        @(posedge iClk); #1;
        iRst = 1'b0;
        #1;
        tests_run++;
        if ({oValid, oC, oV} !== 3'b000 || oS !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_out: got valid=%0b c=%0b v=%0b s=%h want all 0", oValid, oC, oV, oS);
        end
        tests_run++;
        if (oReady !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_ready: got %0b want 1", oReady);
        end
        for (int i = 0; i < S + 2; i++) begin
            drive_idle(1'b1);
            tests_run++;
            if (oValid !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_mid_stale%0d: got valid=%0b want 0", i, oValid);
            end
        end
    endtask

    task automatic test_random_stream();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) != 0)
                drive_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 3) != 0));
            else
                drive_idle(1'($urandom_range(0, 3) != 0));
        end
        drain();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rand_pending: got %0d want 0", exp_q.size());
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random_stream();
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/add_cla_pipe.md
Name: add_cla_pipe

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor, the successor to the fixed 4-bit CLA adder. It is used by the floating-point mantissa and exponent datapaths. The WIDTH-bit operand is split into STAGES equal segments. Each segment is built from 4-bit CLA groups with a group-level lookahead, and the carry between segments is registered. The block has a valid/ready handshake, accepts one operation per cycle, and reports carry-out and signed overflow.

Parameters:
WIDTH, 32, operand/sum width in bits; must be a multiple of 4*STAGES
STAGES, 4, pipeline depth and segment count; 1..WIDTH/4; latency = STAGES cycles

Ports:
iClk  input  1  clock, rising edge
iRst  input  1  synchronous active-high reset
iValid  input  1  input operation valid
oReady  output  1  block can accept an operation this cycle
iA  input  WIDTH  operand A
iB  input  WIDTH  operand B
iC  input  1  carry-in; on subtract, acts as inverted borrow-in
iSub  input  1  0: S=A+B+iC, 1: S=A+~B+iC (iC=1 gives plain A-B)
oValid  output  1  result valid
iReady  input  1  downstream accepts result
oS  output  WIDTH  sum/difference
oC  output  1  carry-out of bit WIDTH-1 (on subtract, borrow = ~oC)
oV  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset: all stage valid bits clear. oValid=0, oS=0, oC=0, oV=0. oReady=1 in the first cycle after reset is released.
- Segment width SEG = WIDTH/STAGES.
  - Stage k (0-based) adds bits [k*SEG +: SEG] using SEG/4 CLA groups. Per-bit G = a&b', P = a|b', with b' = iSub ? ~iB : iB.
  - Group G/P feed a lookahead across the groups in the segment.
  - The segment's carry-out is registered as carry-in of stage k+1. Stage 0 uses iC.
- Skew registers:
  - Operand bits not yet consumed are carried forward with the pipeline.
  - Already-computed sum segments are carried forward to the output.
  - oS, oC and oV are registered outputs of the final stage.
- Handshake: one global enable, en = ~oValid | iReady. oReady = en (combinational).
  - An operation is accepted when iValid & oReady.
  - A result is consumed when oValid & iReady.
  - When en=1, every stage advances and stage-0 valid loads iValid.
  - When en=0, all stages, skew registers and outputs hold, including invalid bubbles.
  - Bubbles are not collapsed.
- Latency: an operation accepted at cycle t appears at oValid in cycle t+STAGES if never stalled.
- Throughput: 1 operation per cycle while iReady=1.
- While oValid=0 the output registers may hold stale data. oS, oC and oV are only meaningful when oValid=1.
- oV: computed in the last stage from the carry into bit WIDTH-1 and oC. Valid for both add and subtract.
- Simultaneous accept and consume: when oValid & iReady & iValid, the pipeline shifts by one. No loss and no duplication.
- Reset mid-operation: iRst has priority over en. All in-flight operations are discarded. Outputs return to reset values on the next edge.
- STAGES=1: single-cycle registered adder. Behaviour is otherwise identical.
- X/garbage on iA, iB, iC and iSub while iValid=0 must not affect any valid result.

Test Plan:
1. Full carry chain, WIDTH=32, STAGES=4: A=0xFFFFFFFF, B=0x00000001, iC=0, iSub=0 -> after 4 cycles S=0x00000000, C=1, V=0. The carry crosses all 3 stage boundaries.
2. Subtract: A=5, B=7, iC=1, iSub=1 -> S=0xFFFFFFFE, C=0 (borrow), V=0. Also A=7, B=5 -> S=2, C=1.
3. Overflow: A=0x7FFFFFFF, B=1, add -> S=0x80000000, V=1, C=0. Also A=0x80000000, B=1, sub, iC=1 -> S=0x7FFFFFFF, V=1, C=1.
4. Throughput: 10 back-to-back random ops, iReady=1 -> oValid high for 10 consecutive cycles starting 4 cycles after the first accept. Results in order and match the reference model.
5. Backpressure:
   - Fill with 4 ops, then hold iReady=0 for 6 cycles -> oReady=0, oS held stable, no op accepted.
   - Release iReady -> the 4 results drain in order, one per cycle.
   - An iValid pulse with oReady=0 is not accepted.
6. Reset mid-flight: 3 ops in flight, assert iRst for 1 cycle -> next cycle oValid=0, oS=0, oC=0, oV=0, oReady=1. No stale result ever emerges.
